// File: rtl/forth_uart_tx.sv
// forth_uart_tx: memory-mapped 8N1 UART transmitter with a transmit FIFO.
// Register window at BASE_ADDR: +0 DATA (write pushes a byte), +1 STATUS
// {overflow, busy, empty, full} (any write clears overflow).
// Optional macro FORTH_UART_TXCOUNT_EN adds a 16-bit sent-frame counter at
// BASE_ADDR+2 (read it, write anything to clear it).
// Bus protocol: dwrite is a single-cycle write strobe with no back-pressure;
// every cycle with dwrite high is one write to daddr, taken at that rising
// edge. Reads are combinational from daddr and return zero wherever nothing
// is mapped, so ddata_read can be OR-ed with other read sources.
// state_dbg_o exposes the transmitter FSM state for observation.

module forth_uart_tx #(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [7:0] BASE_ADDR    = 8'hF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  daddr,
    input  logic [15:0] ddata_write,
    input  logic        dwrite,
    output logic [15:0] ddata_read,
    output logic        tx,
    output logic [1:0]  state_dbg_o
);

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  ADDR_DATA   = BASE_ADDR;
    localparam logic [7:0]  ADDR_STATUS = BASE_ADDR + 8'd1;
    localparam logic [15:0] CLK_LAST    = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] DEPTH_CNT   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t      state_q;
    logic [7:0]  fifo_mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic [15:0] clk_cnt_q;
    logic        tx_q;

    logic [AW:0] fifo_count;
    logic        fifo_full, fifo_empty;
    logic        bit_done;
    logic        wr_data, wr_status;
    logic        pop, push;
    logic [7:0]  fifo_head;
    logic        busy;

    // Only the low byte of the write bus carries data.
    logic unused_wdata;
    assign unused_wdata = ^ddata_write[15:8];

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_count == DEPTH_CNT);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign bit_done   = (clk_cnt_q == CLK_LAST);
    assign busy       = (state_q != ST_IDLE);

    assign wr_data   = dwrite && !reset && (daddr == ADDR_DATA);
    assign wr_status = dwrite && !reset && (daddr == ADDR_STATUS);

    // The FSM takes the head when idle, or at the end of a stop bit so frames
    // chain with no idle gap. A pop in the same cycle frees a slot for a push.
    assign pop  = !fifo_empty && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_done));
    assign push = wr_data && (!fifo_full || pop);

    // Next pointer / overflow values; a dropped push sets overflow sticky.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
        overflow_d = overflow_q;
        if (wr_status) begin
            overflow_d = 1'b0;
        end else if (wr_data && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO pointers and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= ddata_write[7:0];
        end
    end

    // Transmitter FSM: start bit, 8 data bits LSB first, stop bit; tx registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tx_q      <= 1'b1;
            shift_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            clk_cnt_q <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q      <= 1'b1;
                    clk_cnt_q <= 16'd0;
                    bit_idx_q <= 3'd0;
                    if (pop) begin
                        shift_q <= fifo_head;
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        clk_cnt_q <= 16'd0;
                        bit_idx_q <= 3'd0;
                        tx_q      <= shift_q[0];
                        state_q   <= ST_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        clk_cnt_q <= 16'd0;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= 3'd0;
                            tx_q      <= 1'b1;
                            state_q   <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        clk_cnt_q <= 16'd0;
                        if (pop) begin
                            shift_q <= fifo_head;
                            tx_q    <= 1'b0;
                            state_q <= ST_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FORTH_UART_TXCOUNT_EN
    localparam logic [7:0] ADDR_COUNT = BASE_ADDR + 8'd2;
    logic [15:0] sent_cnt_q;

    // Sent-frame counter: counts stop-bit completions, wraps, write clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            sent_cnt_q <= 16'd0;
        end else if (dwrite && (daddr == ADDR_COUNT)) begin
            sent_cnt_q <= 16'd0;
        end else if ((state_q == ST_STOP) && bit_done) begin
            sent_cnt_q <= sent_cnt_q + 16'd1;
        end
    end

    // Read mux: zero for write-only and unmapped addresses.
    always_comb begin
        ddata_read = 16'h0000;
        if (daddr == ADDR_STATUS) begin
            ddata_read = {12'h000, overflow_q, busy, fifo_empty, fifo_full};
        end else if (daddr == ADDR_COUNT) begin
            ddata_read = sent_cnt_q;
        end
    end
`else
    // Read mux: zero for write-only and unmapped addresses.
    always_comb begin
        ddata_read = 16'h0000;
        if (daddr == ADDR_STATUS) begin
            ddata_read = {12'h000, overflow_q, busy, fifo_empty, fifo_full};
        end
    end
`endif

    assign tx          = tx_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_forth_uart_tx.sv
// Bench for forth_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=F0.
// Bytes expected on the line are queued when written; a line monitor decodes
// each frame and compares it against the queue head.

module tb_forth_uart_tx;

    localparam int         CPB  = 4;
    localparam int         DEPTH = 4;
    localparam logic [7:0] BASE = 8'hF0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  daddr = 8'h00;
    logic [15:0] ddata_write = 16'h0000;
    logic        dwrite = 1'b0;
    logic [15:0] ddata_read;
    logic        tx;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail = 0;
    int frames_seen = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];

    // monitor state
    logic       mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;
    int         start_cyc = 0;
    int         start_cyc_prev = 0;

    forth_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .daddr(daddr),
        .ddata_write(ddata_write),
        .dwrite(dwrite),
        .ddata_read(ddata_read),
        .tx(tx),
        .state_dbg_o(state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: samples tx on falling edges, decodes 8N1 frames.
    always @(negedge clk) begin
        if (reset) begin
            mon_active = 1'b0;
            mon_cnt = 0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt = 0;
                mon_byte = 8'h00;
                start_cyc_prev = start_cyc;
                start_cyc = cyc;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 1) begin
                n_checks++;
                if (tx !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_bit: tx=%b required 0", tx);
                end
            end else if (mon_cnt >= 5 && mon_cnt <= 33 && ((mon_cnt - 5) % 4) == 0) begin
                mon_byte[(mon_cnt - 5) / 4] = tx;
            end else if (mon_cnt == 37) begin
                n_checks++;
                if (tx !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stop_bit: tx=%b required 1", tx);
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame_data: got unexpected frame %02h, none required", mon_byte);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (mon_byte !== e) begin
                        n_fail++;
                        $display("FAIL frame_data: got %02h required %02h", mon_byte, e);
                    end
                end
                frames_seen++;
            end else if (mon_cnt == 39) begin
                mon_active = 1'b0;
            end
        end
    end

    // driver tasks
    task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        daddr = a;
        ddata_write = d;
        dwrite = 1'b1;
        @(posedge clk);
        #1;
        dwrite = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [15:0] d);
        @(negedge clk);
        daddr = a;
        #1;
        d = ddata_read;
    endtask

    task automatic wait_idle();
        logic [15:0] rd;
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            bus_read(BASE + 8'd1, rd);
            if (rd[2:0] == 3'b010) done = 1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL wait_idle: status=%04h required idle and empty", rd);
        end
    endtask

    task automatic wait_frames(input int target);
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (frames_seen >= target) done = 1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL wait_frames: saw %0d required %0d", frames_seen, target);
        end
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: tx=%b state=%0d required tx=1 state=0", tx, state_dbg);
        end
        reset = 1'b0;
        bus_read(BASE + 8'd1, rd);
        n_checks++;
        if (rd !== 16'h0002) begin
            n_fail++;
            $display("FAIL reset_status: got %04h required 0002", rd);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        logic exp_tx;
        int f0;
        b = 8'h55;
        wait_idle();
        f0 = frames_seen;
        exp_q.push_back(b);
        bus_write(BASE, 16'h1255);
        daddr = BASE + 8'd1;
        #1;
        n_checks++;
        if (tx !== 1'b1 || ddata_read !== 16'h0000) begin
            n_fail++;
            $display("FAIL write_edge: tx=%b status=%04h required tx=1 status=0000", tx, ddata_read);
        end
        for (int k = 1; k <= 41; k++) begin
            @(posedge clk);
            #1;
            if (k <= 4) exp_tx = 1'b0;
            else if (k <= 36) exp_tx = b[(k - 5) / 4];
            else exp_tx = 1'b1;
            n_checks++;
            if (tx !== exp_tx) begin
                n_fail++;
                $display("FAIL frame_wave: edge N+%0d tx=%b required %b", k, tx, exp_tx);
            end
        end
        n_checks++;
        if (ddata_read !== 16'h0002) begin
            n_fail++;
            $display("FAIL after_frame_status: got %04h required 0002", ddata_read);
        end
        wait_frames(f0 + 1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_st;
        int f0;
        wait_idle();
        f0 = frames_seen;
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        bus_write(BASE, 16'h0041);
        bus_write(BASE, 16'h0042);
        for (int i = 1; i <= 79; i++) begin
            @(negedge clk);
            daddr = BASE + 8'd1;
            #1;
            exp_st = (i <= 40) ? 16'h0004 : 16'h0006;
            n_checks++;
            if (ddata_read !== exp_st) begin
                n_fail++;
                $display("FAIL b2b_status: edge N+%0d got %04h required %04h", i, ddata_read, exp_st);
            end
        end
        wait_frames(f0 + 2);
        n_checks++;
        if (start_cyc - start_cyc_prev != 40) begin
            n_fail++;
            $display("FAIL b2b_gap: start spacing %0d cycles required 40", start_cyc - start_cyc_prev);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] rd;
        int f0;
        wait_idle();
        f0 = frames_seen;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(8'hA0 + 8'(i));
            bus_write(BASE, 16'h00A0 + 16'(i));
        end
        bus_read(BASE + 8'd1, rd);
        n_checks++;
        if (rd !== 16'h000D) begin
            n_fail++;
            $display("FAIL overflow_status: got %04h required 000d", rd);
        end
        bus_write(BASE + 8'd1, 16'hFFFF);
        bus_read(BASE + 8'd1, rd);
        n_checks++;
        if (rd !== 16'h0005) begin
            n_fail++;
            $display("FAIL overflow_clear: got %04h required 0005", rd);
        end
        wait_frames(f0 + 5);
        wait_idle();
        repeat (60) @(posedge clk);
        n_checks++;
        if (frames_seen != f0 + 5) begin
            n_fail++;
            $display("FAIL overflow_frames: got %0d frames required %0d", frames_seen - f0, 5);
        end
    endtask

    task automatic test_read_map();
        logic [15:0] rd;
        logic [7:0] addrs [5];
        int f0;
        addrs = '{8'h00, 8'hEF, 8'hF0, 8'hF3, 8'hFF};
        wait_idle();
        f0 = frames_seen;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'h30 + 8'(i));
            bus_write(BASE, 16'hC530 + 16'(i));
        end
        bus_read(BASE + 8'd1, rd);
        n_checks++;
        if (rd !== 16'h0005) begin
            n_fail++;
            $display("FAIL map_status_full: got %04h required 0005", rd);
        end
        for (int i = 0; i < 5; i++) begin
            bus_read(addrs[i], rd);
            n_checks++;
            if (rd !== 16'h0000) begin
                n_fail++;
                $display("FAIL map_unmapped: addr %02h got %04h required 0000", addrs[i], rd);
            end
        end
        wait_frames(f0 + 5);
        wait_idle();
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] rd;
        int f0;
        wait_idle();
        bus_write(BASE, 16'h0000);
        repeat (11) @(posedge clk);
        #1;
        n_checks++;
        if (state_dbg !== 2'd2 || tx !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_frame_pre: state=%0d tx=%b required state=2 tx=0", state_dbg, tx);
        end
        reset = 1'b1;
        daddr = BASE;
        ddata_write = 16'h0077;
        dwrite = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (tx !== 1'b1 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_frame_abort: tx=%b state=%0d required tx=1 state=0", tx, state_dbg);
        end
        @(posedge clk);
        #1;
        dwrite = 1'b0;
        reset = 1'b0;
        bus_read(BASE + 8'd1, rd);
        n_checks++;
        if (rd !== 16'h0002) begin
            n_fail++;
            $display("FAIL mid_frame_status: got %04h required 0002", rd);
        end
        f0 = frames_seen;
        repeat (60) @(posedge clk);
        #1;
        n_checks++;
        if (frames_seen != f0 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_frame_quiet: frames=%0d tx=%b required 0 frames tx=1", frames_seen - f0, tx);
        end
    endtask

    task automatic test_counter();
        logic [15:0] rd;
        int f0;
        wait_idle();
        f0 = frames_seen;
`ifdef FORTH_UART_TXCOUNT_EN
        bus_write(BASE + 8'd2, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'h5A + 8'(i));
            bus_write(BASE, 16'h005A + 16'(i));
        end
        wait_frames(f0 + 3);
        wait_idle();
        bus_read(BASE + 8'd2, rd);
        n_checks++;
        if (rd !== 16'h0003) begin
            n_fail++;
            $display("FAIL count_value: got %04h required 0003", rd);
        end
        bus_write(BASE + 8'd2, 16'h1234);
        bus_read(BASE + 8'd2, rd);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL count_clear: got %04h required 0000", rd);
        end
`else
        exp_q.push_back(8'h5A);
        bus_write(BASE, 16'h005A);
        wait_frames(f0 + 1);
        wait_idle();
        bus_read(BASE + 8'd2, rd);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL count_absent: got %04h required 0000", rd);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_read_map();
        test_reset_mid_frame();
        test_counter();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_queue: %0d bytes never sent, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/forth_uart_tx.md
FORTH_UART_TX -- requirements
Module: forth_uart_tx

Interface
REQ-001 CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 FIFO_DEPTH, default 8, transmit FIFO entries; power of two, 2..64.
REQ-003 BASE_ADDR, default 8'hF0, first data-bus address of the register window.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 daddr  input  8  CPU data-bus address.
REQ-007 ddata_write  input  16  CPU write data; only bits 7:0 are used.
REQ-008 dwrite  input  1  CPU write strobe; one write per cycle it is high.
REQ-009 ddata_read  output  16  read data for the current daddr.
REQ-010 tx  output  1  serial line, 8N1, LSB first, idle high.

Function
REQ-011 Register map: BASE_ADDR+0 DATA (write only), BASE_ADDR+1 STATUS (read/write); all other addresses are unmapped.
REQ-012 ddata_read SHALL be combinational from daddr: STATUS reads {12'b0, overflow, busy, empty, full}; DATA, unmapped addresses and any undefined bits read 0, so the output can be OR-muxed with data RAM.
REQ-013 A write to DATA pushes ddata_write[7:0] into the FIFO at that rising edge.
REQ-014 Push while full: the byte is dropped and sticky overflow is set, unless a pop occurs in the same cycle, in which case the push is accepted and overflow is unchanged.
REQ-015 A write to STATUS (any data) clears overflow; there are no other effects.
REQ-016 The FIFO is circular, with read and write pointers of log2(FIFO_DEPTH)+1 bits.
REQ-017 full = exactly FIFO_DEPTH entries; empty = zero entries; count never exceeds FIFO_DEPTH and never underflows.
REQ-018 Transmitter FSM states: IDLE, START, DATA, STOP.
REQ-019 In IDLE with the FIFO non-empty, the FSM pops the head into the shift register and enters START on the next edge.
REQ-020 In START, tx=0 for CLKS_PER_BIT cycles.
REQ-021 In DATA, the 8 bits are sent LSB first, each for CLKS_PER_BIT cycles, with a 3-bit bit index.
REQ-022 In STOP, tx=1 for CLKS_PER_BIT cycles.
REQ-023 At the end of STOP: if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
REQ-024 Latency: a DATA write at edge N with the FIFO empty and the FSM in IDLE gives the pop at edge N+1 and tx=0 from edge N+1.
REQ-025 busy = (state != IDLE).
REQ-026 A push and a pop in the same cycle leave count unchanged and keep FIFO order.
REQ-027 tx SHALL be driven from a register, so it is glitch-free.

Reset
REQ-028 While reset is high at a rising edge, these are forced: state=IDLE, tx=1, FIFO pointers=0 (empty), overflow=0, bit and cycle counters=0.
REQ-029 Reset mid-frame aborts the frame, tx returns high on the next edge, and FIFO contents are discarded.
REQ-030 Bus writes while reset is high are ignored.

Configuration
REQ-031 Macro FORTH_UART_TXCOUNT_EN: when defined, adds a 16-bit sent counter readable at BASE_ADDR+2.
REQ-032 With the macro, the counter increments at each STOP completion and wraps from 16'hFFFF to 0.
REQ-033 With the macro, the counter resets to 0 and is cleared by any write to BASE_ADDR+2.
REQ-034 Without the macro, no counter logic exists and BASE_ADDR+2 reads 0 like any unmapped address.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=F0)
REQ-035 Reset, then write 16'h1255 to F0: tx low for 4 cycles from edge N+1, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles; STATUS reads 4'b0010 afterwards.
REQ-036 Write 41 and 42 back-to-back: two frames separated by no idle cycles; busy=1 throughout; empty=1 after the second pop.
REQ-037 Write 6 bytes in consecutive cycles starting in IDLE: the first pops immediately, 4 are queued, and the 6th is dropped.
   - full=1 and overflow=1.
   - Exactly 5 frames are sent.
   - A write to F1 then reads overflow=0.
REQ-038 Reset asserted in the middle of the DATA state: tx=1 on the next edge and STATUS reads 4'b0010; no further frames.
REQ-039 Read addresses 00, EF, F0 and F3 give 16'h0000; F1 with the FIFO holding 4 entries and the FSM busy gives 16'h0005 plus the overflow bit.
REQ-040 With FORTH_UART_TXCOUNT_EN: send 3 bytes, then F2 reads 3; a write to F2 gives 0.
REQ-041 Without FORTH_UART_TXCOUNT_EN, F2 reads 0.
